// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch controller signal bundle: pre-divided ticks, button pulses,
// mode switches in; BCD digits, blanking requests and run status out.
interface stopwatch_ctrl_if;
  logic       tick_1hz;
  logic       tick_2hz;
  logic       pause_p;
  logic       clear_p;
  logic       adj;
  logic       sel;
  logic [2:0] min1;
  logic [3:0] min0;
  logic [2:0] sec1;
  logic [3:0] sec0;
  logic       blank_min;
  logic       blank_sec;
  logic       running;

  modport master (
    output tick_1hz, tick_2hz, pause_p, clear_p, adj, sel,
    input  min1, min0, sec1, sec0, blank_min, blank_sec, running
  );

  modport slave (
    input  tick_1hz, tick_2hz, pause_p, clear_p, adj, sel,
    output min1, min0, sec1, sec0, blank_min, blank_sec, running
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// mm:ss stopwatch sequencer: RUN/PAUSE/ADJ mode FSM plus BCD digit
// registers, adjust-mode stepping and blink-phase blanking requests.
module stopwatch_ctrl #(
  parameter int unsigned MIN1_MAX = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  stopwatch_ctrl_if.slave bus
);

  localparam logic [2:0] M1_MAX = 3'(MIN1_MAX);

  typedef enum logic [1:0] {RUN, PAUSE, ADJ} state_t;

  state_t     state, state_nxt;
  logic       paused_save, paused_save_nxt;
  logic       blink_ph, blink_ph_nxt;
  logic [2:0] min1_q, min1_nxt;
  logic [3:0] min0_q, min0_nxt;
  logic [2:0] sec1_q, sec1_nxt;
  logic [3:0] sec0_q, sec0_nxt;
  logic       blank_min_q, blank_min_nxt;
  logic       blank_sec_q, blank_sec_nxt;
  logic       running_q, running_nxt;

  // incremented field values; seconds and minutes wrap independently
  logic [2:0] min1_inc, sec1_inc;
  logic [3:0] min0_inc, sec0_inc;
  logic       sec_wrap;

  // single-step increment of each field
  always_comb begin
    sec_wrap = (sec0_q == 4'd9) && (sec1_q == 3'd5);
    sec0_inc = (sec0_q == 4'd9) ? 4'd0 : sec0_q + 4'd1;
    sec1_inc = sec1_q;
    if (sec0_q == 4'd9) sec1_inc = (sec1_q == 3'd5) ? 3'd0 : sec1_q + 3'd1;
    min0_inc = (min0_q == 4'd9) ? 4'd0 : min0_q + 4'd1;
    min1_inc = min1_q;
    if (min0_q == 4'd9) min1_inc = (min1_q == M1_MAX) ? 3'd0 : min1_q + 3'd1;
  end

  // next-state, digit and output logic
  always_comb begin
    state_nxt       = state;
    paused_save_nxt = paused_save;
    blink_ph_nxt    = blink_ph;
    min1_nxt        = min1_q;
    min0_nxt        = min0_q;
    sec1_nxt        = sec1_q;
    sec0_nxt        = sec0_q;

    unique case (state)
      RUN:     if (bus.adj) state_nxt = ADJ; else if (bus.pause_p) state_nxt = PAUSE;
      PAUSE:   if (bus.adj) state_nxt = ADJ; else if (bus.pause_p) state_nxt = RUN;
      ADJ:     if (!bus.adj) state_nxt = paused_save ? PAUSE : RUN;
      default: state_nxt = RUN;
    endcase

    if (state != ADJ && state_nxt == ADJ) begin
      paused_save_nxt = (state == PAUSE);
      blink_ph_nxt    = 1'b0;
    end
    if (state == ADJ && bus.tick_2hz) blink_ph_nxt = ~blink_ph;

    // counting uses the current state, so a same-edge pause still counts
    if (state == RUN && bus.tick_1hz) begin
      sec0_nxt = sec0_inc;
      sec1_nxt = sec1_inc;
      if (sec_wrap) begin
        min0_nxt = min0_inc;
        min1_nxt = min1_inc;
      end
    end else if (state == ADJ && bus.tick_2hz) begin
      if (bus.sel) begin
        sec0_nxt = sec0_inc;
        sec1_nxt = sec1_inc;
      end else begin
        min0_nxt = min0_inc;
        min1_nxt = min1_inc;
      end
    end

    if (bus.clear_p) begin
      min1_nxt = '0;
      min0_nxt = '0;
      sec1_nxt = '0;
      sec0_nxt = '0;
    end

    blank_min_nxt = (state_nxt == ADJ) && !bus.sel && blink_ph_nxt;
    blank_sec_nxt = (state_nxt == ADJ) &&  bus.sel && blink_ph_nxt;
    running_nxt   = (state_nxt == RUN);
  end

  // state, digit and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      paused_save <= 1'b0;
      blink_ph    <= 1'b0;
      min1_q      <= '0;
      min0_q      <= '0;
      sec1_q      <= '0;
      sec0_q      <= '0;
      blank_min_q <= 1'b0;
      blank_sec_q <= 1'b0;
      running_q   <= 1'b1;
    end else begin
      state       <= state_nxt;
      paused_save <= paused_save_nxt;
      blink_ph    <= blink_ph_nxt;
      min1_q      <= min1_nxt;
      min0_q      <= min0_nxt;
      sec1_q      <= sec1_nxt;
      sec0_q      <= sec0_nxt;
      blank_min_q <= blank_min_nxt;
      blank_sec_q <= blank_sec_nxt;
      running_q   <= running_nxt;
    end
  end

  assign bus.min1      = min1_q;
  assign bus.min0      = min0_q;
  assign bus.sec1      = sec1_q;
  assign bus.sec0      = sec0_q;
  assign bus.blank_min = blank_min_q;
  assign bus.blank_sec = blank_sec_q;
  assign bus.running   = running_q;

endmodule
